// File: rtl/hilo_if.sv
// HI/LO unit bus: EX-stage issue/move/read requests toward the unit and
// architectural HI/LO plus status back to the pipeline.
interface hilo_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        mthi;
  logic        mtlo;
  logic [31:0] wd;
  logic        mf_req;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        stall;
  logic        done;
  logic        div_zero;

  modport master (
    output start, op, a, b, mthi, mtlo, wd, mf_req,
    input  hi, lo, busy, stall, done, div_zero
  );

  modport slave (
    input  start, op, a, b, mthi, mtlo, wd, mf_req,
    output hi, lo, busy, stall, done, div_zero
  );
endinterface

// File: rtl/hilo_ctrl.sv
// Iterative multiply/divide unit owning the HI/LO registers.
//
// state | meaning
// IDLE  | accepts start and mthi/mtlo; HI/LO writable by moves
// MUL   | shift-add multiply on magnitudes, one multiplier bit per cycle
// DIV   | restoring divide on magnitudes, one quotient bit per cycle
// FIN   | sign-fix results, write HI/LO, pulse done
//
// Operands are converted to magnitudes at launch so both loops are purely
// unsigned; the sign fix-up happens once in FIN. HI/LO are only touched by
// moves in IDLE and by the FIN write, so in-flight values never leak out.
module hilo_ctrl (
  input  logic   clk,
  input  logic   rst,
  hilo_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} state_t;

  state_t      state;
  logic [4:0]  cnt;
  logic        is_div;
  logic [31:0] a_q;
  logic [31:0] acc_hi;   // partial product high half / partial remainder
  logic [31:0] acc_lo;   // multiplier shifting out / dividend->quotient
  logic [31:0] m_q;      // multiplicand magnitude / divisor magnitude
  logic        neg_res;
  logic        neg_rem;
  logic        dz_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic        busy_q;
  logic        done_q;
  logic        div_zero_q;

  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [32:0] mul_sum;
  logic        div_ge;
  logic [31:0] div_sub;
  logic [63:0] prod_res;
  logic [31:0] quo_res;
  logic [31:0] rem_res;

  // Operand magnitudes and per-iteration arithmetic of both loops.
  always_comb begin
    mag_a    = (bus.op[0] && bus.a[31]) ? (32'd0 - bus.a) : bus.a;
    mag_b    = (bus.op[0] && bus.b[31]) ? (32'd0 - bus.b) : bus.b;
    mul_sum  = {1'b0, acc_hi} + {1'b0, (acc_lo[0] ? m_q : 32'd0)};
    div_ge   = {acc_hi, acc_lo[31]} >= {1'b0, m_q};
    div_sub  = {acc_hi[30:0], acc_lo[31]} - m_q;
    prod_res = neg_res ? (64'd0 - {acc_hi, acc_lo}) : {acc_hi, acc_lo};
    quo_res  = neg_res ? (32'd0 - acc_lo) : acc_lo;
    rem_res  = neg_rem ? (32'd0 - acc_hi) : acc_hi;
  end

  // Sequencing FSM, iteration datapath and the architectural HI/LO.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 5'd0;
      is_div     <= 1'b0;
      a_q        <= 32'd0;
      acc_hi     <= 32'd0;
      acc_lo     <= 32'd0;
      m_q        <= 32'd0;
      neg_res    <= 1'b0;
      neg_rem    <= 1'b0;
      dz_q       <= 1'b0;
      hi_q       <= 32'd0;
      lo_q       <= 32'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.mthi) hi_q <= bus.wd;
          if (bus.mtlo) lo_q <= bus.wd;
          if (bus.start) begin
            cnt     <= 5'd0;
            is_div  <= bus.op[1];
            a_q     <= bus.a;
            acc_hi  <= 32'd0;
            acc_lo  <= bus.op[1] ? mag_a : mag_b;
            m_q     <= bus.op[1] ? mag_b : mag_a;
            neg_res <= bus.op[0] & (bus.a[31] ^ bus.b[31]);
            neg_rem <= bus.op[0] & bus.a[31];
            dz_q    <= bus.op[1] & (bus.b == 32'd0);
            busy_q  <= 1'b1;
            state   <= bus.op[1] ? DIV : MUL;
          end
        end
        MUL: begin
          acc_hi <= mul_sum[32:1];
          acc_lo <= {mul_sum[0], acc_lo[31:1]};
          cnt    <= cnt + 5'd1;
          if (cnt == 5'd31) state <= FIN;
        end
        DIV: begin
          if (div_ge) begin
            acc_hi <= div_sub;
            acc_lo <= {acc_lo[30:0], 1'b1};
          end else begin
            acc_hi <= {acc_hi[30:0], acc_lo[31]};
            acc_lo <= {acc_lo[30:0], 1'b0};
          end
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) state <= FIN;
        end
        FIN: begin
          if (!is_div) begin
            hi_q <= prod_res[63:32];
            lo_q <= prod_res[31:0];
          end else if (dz_q) begin
            hi_q <= a_q;
            lo_q <= 32'hFFFF_FFFF;
          end else begin
            hi_q <= rem_res;
            lo_q <= quo_res;
          end
          done_q     <= 1'b1;
          div_zero_q <= dz_q;
          busy_q     <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.div_zero = div_zero_q;
  assign bus.stall    = busy_q & (bus.start | bus.mf_req | bus.mthi | bus.mtlo);

endmodule

// File: tb/tb_hilo_ctrl.sv
// Directed bench for hilo_ctrl: a behavioural reference (64-bit native
// arithmetic) feeds a result queue at issue time; results are popped and
// compared when done pulses. HI/LO are tracked in a bench-side model.
module tb_hilo_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  hilo_if bus ();

  hilo_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [64:0] sb_q[$];
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [64:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [64:0] res;
    logic [63:0] p;
    longint sa, sb, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    res = '0;
    case (op)
      2'b00: begin p = {32'd0, a} * {32'd0, b}; res = {1'b0, p}; end
      2'b01: begin p = sa * sb; res = {1'b0, p}; end
      default: begin
        if (b == 32'd0) res = {1'b1, a, 32'hFFFF_FFFF};
        else if (op == 2'b10) res = {1'b0, a % b, a / b};
        else begin
          q = sa / sb;
          r = sa % sb;
          res = {1'b0, r[31:0], q[31:0]};
        end
      end
    endcase
    return res;
  endfunction

  // side: 0 none, 1 mf_req while busy, 2 mthi while busy, 3 start while busy
  // lmt: assert mtlo together with start (wd = 0xA5A5_0001)
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int side, input bit lmt);
    int n;
    bit hold_ok, stall_ok;
    logic [64:0] exp;
    bus.op = op; bus.a = a; bus.b = b; bus.start = 1'b1;
    if (lmt) begin bus.mtlo = 1'b1; bus.wd = 32'hA5A5_0001; end
    sb_q.push_back(model(op, a, b));
    tick();
    bus.start = 1'b0; bus.mtlo = 1'b0;
    if (lmt) begin
      m_lo = 32'hA5A5_0001;
      check({tag, "_launch_mtlo"}, bus.lo, m_lo);
    end
    check({tag, "_busy"}, bus.busy, 1'b1);
    hold_ok = 1'b1; stall_ok = 1'b1;
    n = 0;
    while (bus.done !== 1'b1 && n < 50) begin
      if (bus.hi !== m_hi || bus.lo !== m_lo) hold_ok = 1'b0;
      case (side)
        1: bus.mf_req = 1'b1;
        2: begin bus.mthi = 1'b1; bus.wd = 32'h0000_1234; end
        3: if (n >= 5 && n < 10) begin
             bus.start = 1'b1; bus.op = 2'b00; bus.a = 32'd9; bus.b = 32'd9;
           end else bus.start = 1'b0;
        default: ;
      endcase
      #0;
      if (bus.stall !== (side != 0 && !(side == 3 && (n < 5 || n >= 10)))) stall_ok = 1'b0;
      tick();
      n++;
    end
    check({tag, "_latency"}, n, 33);
    check({tag, "_hold"}, hold_ok, 1'b1);
    if (side != 0) check({tag, "_stall"}, stall_ok, 1'b1);
    if (sb_q.size() > 0) begin
      exp = sb_q.pop_front();
      m_hi = exp[63:32];
      m_lo = exp[31:0];
      check({tag, "_hi"}, bus.hi, exp[63:32]);
      check({tag, "_lo"}, bus.lo, exp[31:0]);
      check({tag, "_dz"}, bus.div_zero, exp[64]);
    end
    check({tag, "_idle_busy"}, bus.busy, 1'b0);
    if (side != 0) check({tag, "_idle_stall"}, bus.stall, 1'b0);
    bus.mf_req = 1'b0; bus.mthi = 1'b0; bus.start = 1'b0;
    tick();
    check({tag, "_done_pulse"}, {bus.done, bus.busy}, 2'b00);
  endtask

  initial begin
    int n;
    bit no_done;
    bus.start = 1'b0; bus.op = 2'b00; bus.a = '0; bus.b = '0;
    bus.mthi = 1'b0; bus.mtlo = 1'b0; bus.wd = '0; bus.mf_req = 1'b0;
    rst = 1'b1;
    tick(); tick();
    check("reset_hilo", {bus.hi, bus.lo}, 64'd0);
    check("reset_flags", {bus.busy, bus.stall, bus.done, bus.div_zero}, 4'b0000);
    rst = 1'b0;
    tick();

    run_op("multu_max", 2'b00, 32'hFFFF_FFFF, 32'd2, 0, 1'b0);
    run_op("mult_neg", 2'b01, 32'hFFFF_FFFD, 32'd7, 0, 1'b0);
    run_op("div_neg", 2'b11, 32'hFFFF_FFF9, 32'd2, 0, 1'b0);
    run_op("divu_zero", 2'b10, 32'd100, 32'd0, 0, 1'b0);
    run_op("div_ovf", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
    run_op("div_zero_s", 2'b11, 32'hFFFF_FF00, 32'd0, 0, 1'b0);
    run_op("mult_mf", 2'b01, 32'd12345, 32'hFFFF_0000, 1, 1'b0);
    run_op("mthi_busy", 2'b10, 32'd1000, 32'd7, 2, 1'b0);
    run_op("start_busy", 2'b01, 32'h7FFF_FFFF, 32'h8000_0000, 3, 1'b0);
    run_op("launch_mtlo", 2'b00, 32'd3, 32'd5, 0, 1'b1);
    for (int i = 0; i < 6; i++)
      run_op("rand", 2'(i), $urandom, (i % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom, 0, 1'b0);

    // moves in IDLE
    bus.mthi = 1'b1; bus.wd = 32'h0000_1234;
    tick();
    bus.mthi = 1'b0;
    m_hi = 32'h0000_1234;
    check("mthi_idle", {bus.hi, bus.lo}, {m_hi, m_lo});
    bus.mthi = 1'b1; bus.mtlo = 1'b1; bus.wd = 32'hCAFE_F00D;
    tick();
    bus.mthi = 1'b0; bus.mtlo = 1'b0;
    m_hi = 32'hCAFE_F00D; m_lo = 32'hCAFE_F00D;
    check("mthi_mtlo_both", {bus.hi, bus.lo}, {m_hi, m_lo});

    // reset aborts a divide partway through
    bus.op = 2'b11; bus.a = 32'd77; bus.b = 32'd5; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (9) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_hi = 32'd0; m_lo = 32'd0;
    check("rst_abort_hilo", {bus.hi, bus.lo}, 64'd0);
    check("rst_abort_busy", bus.busy, 1'b0);
    no_done = 1'b1;
    for (n = 0; n < 40; n++) begin
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) no_done = 1'b0;
      tick();
    end
    check("rst_abort_nodone", no_done, 1'b1);
    run_op("after_rst", 2'b11, 32'hFFFF_FF9C, 32'd7, 0, 1'b0);

    // reset wins over a simultaneous move and start
    rst = 1'b1; bus.mthi = 1'b1; bus.mtlo = 1'b1; bus.wd = 32'h5555_AAAA; bus.start = 1'b1;
    tick();
    rst = 1'b0; bus.mthi = 1'b0; bus.mtlo = 1'b0; bus.start = 1'b0;
    check("rst_prio_hilo", {bus.hi, bus.lo}, 64'd0);
    check("rst_prio_busy", bus.busy, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/hilo_ctrl.md
HILO_CTRL -- requirements
Module: hilo_ctrl

Interface
REQ-001 SHALL provide clk  input  1  pipeline clock; all state updates on rising edge.
REQ-002 SHALL provide rst  input  1  synchronous active-high reset.
REQ-003 SHALL provide start  input  1  issue mult/div from EX stage.
REQ-004 SHALL provide op  input  2  00 multu, 01 mult, 10 divu, 11 div.
REQ-005 SHALL provide a  input  32  rs operand (multiplicand / dividend).
REQ-006 SHALL provide b  input  32  rt operand (multiplier / divisor).
REQ-007 SHALL provide mthi, mtlo  input  1 each  move-to-HI / move-to-LO.
REQ-008 SHALL provide wd  input  32  write data for mthi/mtlo.
REQ-009 SHALL provide mf_req  input  1  EX-stage instruction reads HI or LO (mfhi/mflo).
REQ-010 SHALL provide hi, lo  output  32 each  architectural HI/LO registers.
REQ-011 SHALL provide busy  output  1  iterative operation in progress.
REQ-012 SHALL provide stall  output  1  freeze IF/ID/EX, bubble into EX/MEM register.
REQ-013 SHALL provide done  output  1  one-cycle pulse when results written to hi/lo.
REQ-014 SHALL provide div_zero  output  1  one-cycle pulse with done when div/divu had b==0.

Function
REQ-015 SHALL implement FSM states IDLE, MUL, DIV, FIN.
REQ-016 IDLE: start sampled high -> latch a, b, op; op[1]=0 -> MUL, op[1]=1 -> DIV; 5-bit iteration counter cleared.
REQ-017 MUL: shift-add, one multiplier bit per cycle, 32 cycles; counter==31 -> FIN.
REQ-018 DIV: restoring division, one quotient bit per cycle, 32 cycles; counter==31 -> FIN.
REQ-019 FIN: write hi/lo, pulse done, return to IDLE; no new start accepted in FIN.
REQ-020 Latency: start sampled at edge N -> hi/lo updated at edge N+33; done high during cycle following edge N+33.
REQ-021 busy SHALL be high in MUL, DIV, FIN; low in IDLE.
REQ-022 Multiply results: hi = upper 32, lo = lower 32 of 64-bit product.
REQ-023 Divide results: lo = quotient, hi = remainder.
REQ-024 Signed ops: iterate on magnitudes; product negated if a[31]^b[31]; quotient negated if a[31]^b[31]; remainder takes sign of a.
REQ-025 Signed corner case: a=0x80000000, b=0xFFFFFFFF div -> lo=0x80000000, hi=0.
REQ-026 Divide by zero (b==0, div or divu): full 32-cycle duration; hi=a, lo=0xFFFFFFFF; div_zero pulses with done.
REQ-027 stall = busy & (start | mf_req | mthi | mtlo); stall SHALL be zero when busy low.
REQ-028 start while busy: ignored until IDLE; held by stall; re-sampled in first IDLE cycle.
REQ-029 mthi/mtlo in IDLE: hi/lo <= wd at next edge; both asserted same cycle -> both written with wd.
REQ-030 mthi/mtlo while busy: ignored (stalled); never corrupt the pending result.
REQ-031 start and mthi/mtlo same IDLE cycle: move write first, operation launches same edge; FIN result overwrites.
REQ-032 hi/lo outputs SHALL hold previous values during MUL/DIV; no intermediate values visible.
REQ-033 Combinational read path: hi/lo are direct register outputs, no bypass of in-flight results.

Reset
REQ-034 rst high at an edge SHALL force IDLE, hi=0, lo=0, counter=0, busy=0, stall=0, done=0, div_zero=0.
REQ-035 rst mid-operation SHALL abort it with no hi/lo write and no done pulse.
REQ-036 rst SHALL take priority over start, mthi, mtlo in the same cycle.

Verification
REQ-037 multu a=0xFFFFFFFF, b=2 -> after 33 edges hi=1, lo=0xFFFFFFFE, done one cycle.
REQ-038 mult a=-3 (0xFFFFFFFD), b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
REQ-039 div a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; divu a=100, b=0 -> hi=100, lo=0xFFFFFFFF, div_zero pulse.
REQ-040 start mult, mf_req high cycles 2..40 -> stall high through FIN, low in first IDLE cycle; hi/lo unchanged until FIN.
REQ-041 mthi wd=0x1234 during busy -> ignored, stall high; same in IDLE -> hi=0x1234 next edge.
REQ-042 rst at cycle 10 of div -> IDLE, hi=lo=0, no done; new start afterwards completes normally.
